// File: rtl/l2_tcdm_arb_pkg.sv
// Shared types and helpers for the L2 TCDM arbiter.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
//
// Contents:
//   tcdm_req_t - request payload {add, wen, wdata, be} at the default 32-bit widths
//   ID_WIDTH   - master-index width for the default two-master build
//   rr_pick    - round-robin winner search starting at a pointer, wrapping at nb
package l2_tcdm_arb_pkg;

  localparam int MAX_MASTERS    = 8;
  localparam int NB_MASTERS_DEF = 2;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ID_WIDTH       = $clog2(NB_MASTERS_DEF);

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0]   add;
    logic                        wen;
    logic [DATA_WIDTH_DEF-1:0]   wdata;
    logic [DATA_WIDTH_DEF/8-1:0] be;
  } tcdm_req_t;

  // Returns the first requesting index at or after ptr, wrapping modulo nb.
  // ptr < nb is assumed, so a single subtraction is enough to wrap.
  // With no request pending the pointer itself is returned (a don't-care).
  function automatic int rr_pick(input logic [MAX_MASTERS-1:0] req,
                                 input int ptr,
                                 input int nb);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (i < nb) begin
        idx = ptr + i;
        if (idx >= nb) idx = idx - nb;
        if (!found && req[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/l2_arb_id_fifo.sv
// Synchronous FIFO holding the master index of every request still awaiting its response.
// Latency: push visible at head/count one cycle after the push edge; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push+pop keeps count.
//
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i      - enqueue data_i at the clock edge
//   pop_i               - dequeue head at the clock edge
//   full_o, empty_o     - occupancy flags
//   count_o             - registered occupancy, 0..DEPTH
//   head_o              - oldest entry
module l2_arb_id_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign count_o = r_count;
  assign head_o  = r_mem[r_rptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/l2_tcdm_arbiter.sv
// Shares one L2 TCDM slave port among NB_MASTERS masters (round-robin, optional debug priority).
// Latency: zero added on the request path; responses routed in the same cycle as s_r_valid_i.
// Backpressure: s_req_o drops while MAX_OUTSTANDING responses are pending; ungranted requests wait.
//
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   prio_en_i                    - PRIO_MASTER wins whenever it requests
//   m_req_i/m_add_i/m_wen_i/
//   m_wdata_i/m_be_i             - per-master request and payload (wen active-low)
//   m_gnt_o                      - per-master grant, one-hot or zero
//   m_r_valid_o, m_r_rdata_o     - per-master response valid, broadcast read data
//   s_req_o/s_add_o/s_wen_o/
//   s_wdata_o/s_be_o, s_gnt_i    - slave request side
//   s_r_valid_i, s_r_rdata_i     - slave response side
//   err_o                        - sticky: response seen with nothing outstanding
//   outstanding_o                - registered count of pending responses
module l2_tcdm_arbiter
  import l2_tcdm_arb_pkg::*;
#(
  parameter int NB_MASTERS      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PRIO_MASTER     = 0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    prio_en_i,
  input  logic [NB_MASTERS-1:0]                   m_req_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]   m_add_i,
  input  logic [NB_MASTERS-1:0]                   m_wen_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  output logic [NB_MASTERS-1:0]                   m_gnt_o,
  output logic [NB_MASTERS-1:0]                   m_r_valid_o,
  output logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]   m_r_rdata_o,
  output logic                                    s_req_o,
  output logic [ADDR_WIDTH-1:0]                   s_add_o,
  output logic                                    s_wen_o,
  output logic [DATA_WIDTH-1:0]                   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                 s_be_o,
  input  logic                                    s_gnt_i,
  input  logic                                    s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                   s_r_rdata_i,
  output logic                                    err_o,
  output logic [$clog2(MAX_OUTSTANDING):0]        outstanding_o
);

  localparam int ID_W = $clog2(NB_MASTERS);

  logic [MAX_MASTERS-1:0] w_req_ext;
  logic [ID_W-1:0]        w_winner;
  logic [ID_W-1:0]        w_head;
  logic                   w_prio_win;
  logic                   w_any_req;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_hs;
  logic                   w_pop;
  logic [ID_W-1:0]        r_rr_ptr;
  logic                   r_err;

  always_comb begin
    w_req_ext                 = '0;
    w_req_ext[NB_MASTERS-1:0] = m_req_i;
  end

  // Winner selection: debug override first, otherwise round-robin from the pointer.
  assign w_prio_win = prio_en_i && m_req_i[PRIO_MASTER];
  assign w_winner   = w_prio_win ? ID_W'(PRIO_MASTER)
                                 : ID_W'(rr_pick(w_req_ext, int'(r_rr_ptr), NB_MASTERS));
  assign w_any_req  = |m_req_i;

  // Full blocks the request regardless of a same-cycle pop, so r_valid never reaches req.
  assign s_req_o   = !rst_i && w_any_req && !w_full;
  assign s_add_o   = m_add_i[w_winner];
  assign s_wen_o   = m_wen_i[w_winner];
  assign s_wdata_o = m_wdata_i[w_winner];
  assign s_be_o    = m_be_i[w_winner];

  assign w_hs  = s_req_o && s_gnt_i;
  assign w_pop = !rst_i && s_r_valid_i && !w_empty;

  always_comb begin
    m_gnt_o = '0;
    if (w_hs) m_gnt_o[w_winner] = 1'b1;
  end

  always_comb begin
    m_r_valid_o = '0;
    if (w_pop) m_r_valid_o[w_head] = 1'b1;
  end

  assign m_r_rdata_o = {NB_MASTERS{s_r_rdata_i}};
  assign err_o       = r_err;

  // The pointer only moves on round-robin wins, so a priority burst does not
  // steal the next turn from whoever was due.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs && !w_prio_win) begin
        if (w_winner == ID_W'(NB_MASTERS - 1)) r_rr_ptr <= '0;
        else                                   r_rr_ptr <= w_winner + 1'b1;
      end
      if (s_r_valid_i && w_empty) r_err <= 1'b1;
    end
  end

  // Every handshake, read or write, gets a response from L2, so every one is tracked.
  l2_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs),
    .data_i  (w_winner),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (outstanding_o),
    .head_o  (w_head)
  );

endmodule

// File: tb/tb_l2_tcdm_arbiter.sv
// Self-checking bench for l2_tcdm_arbiter with a latency-1 slave model and a response scoreboard.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Each granted request pushes its expected routing/data; each slave response pops and compares.
module tb_l2_tcdm_arbiter;
  import l2_tcdm_arb_pkg::*;

  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     prio_en_i;
  logic [NB-1:0]            m_req_i;
  logic [NB-1:0][AW-1:0]    m_add_i;
  logic [NB-1:0]            m_wen_i;
  logic [NB-1:0][DW-1:0]    m_wdata_i;
  logic [NB-1:0][DW/8-1:0]  m_be_i;
  logic [NB-1:0]            m_gnt_o;
  logic [NB-1:0]            m_r_valid_o;
  logic [NB-1:0][DW-1:0]    m_r_rdata_o;
  logic                     s_req_o;
  logic [AW-1:0]            s_add_o;
  logic                     s_wen_o;
  logic [DW-1:0]            s_wdata_o;
  logic [DW/8-1:0]          s_be_o;
  logic                     s_gnt_i;
  logic                     s_r_valid_i;
  logic [DW-1:0]            s_r_rdata_i;
  logic                     err_o;
  logic [$clog2(MO):0]      outstanding_o;

  typedef struct {
    int unsigned mst;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] slv_q[$];
  logic [31:0] mem[bit [31:0]];
  tcdm_req_t   cur[NB];
  int          errors = 0;
  int          checks = 0;

  always #5 clk_i = ~clk_i;

  l2_tcdm_arbiter #(
    .NB_MASTERS      (NB),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO),
    .PRIO_MASTER     (0)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .prio_en_i     (prio_en_i),
    .m_req_i       (m_req_i),
    .m_add_i       (m_add_i),
    .m_wen_i       (m_wen_i),
    .m_wdata_i     (m_wdata_i),
    .m_be_i        (m_be_i),
    .m_gnt_o       (m_gnt_o),
    .m_r_valid_o   (m_r_valid_o),
    .m_r_rdata_o   (m_r_rdata_o),
    .s_req_o       (s_req_o),
    .s_add_o       (s_add_o),
    .s_wen_o       (s_wen_o),
    .s_wdata_o     (s_wdata_o),
    .s_be_o        (s_be_o),
    .s_gnt_i       (s_gnt_i),
    .s_r_valid_i   (s_r_valid_i),
    .s_r_rdata_i   (s_r_rdata_i),
    .err_o         (err_o),
    .outstanding_o (outstanding_o)
  );

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic tcdm_req_t mk(input logic [31:0] add, input logic wen, input logic [31:0] wdata);
    tcdm_req_t t;
    t.add   = add;
    t.wen   = wen;
    t.wdata = wdata;
    t.be    = 4'hF;
    return t;
  endfunction

  task automatic set_master(input int m, input logic req, input tcdm_req_t t);
    m_req_i[m]   = req;
    m_add_i[m]   = t.add;
    m_wen_i[m]   = t.wen;
    m_wdata_i[m] = t.wdata;
    m_be_i[m]    = t.be;
    cur[m]       = t;
  endtask

  // Slave accepted master m's current request: update memory, queue slave data and expectation.
  task automatic accept(input int m);
    exp_t e;
    e.mst = m;
    e.rd  = cur[m].wen;
    if (!cur[m].wen) begin
      mem[cur[m].add] = cur[m].wdata;
      e.data = 32'h0;
    end else begin
      e.data = mem.exists(cur[m].add) ? mem[cur[m].add] : 32'h0;
    end
    exp_q.push_back(e);
    slv_q.push_back(e.data);
  endtask

  task automatic slave_drive(input bit en);
    if (en && slv_q.size() > 0) begin
      s_r_valid_i = 1'b1;
      s_r_rdata_i = slv_q.pop_front();
    end else begin
      s_r_valid_i = 1'b0;
      s_r_rdata_i = 32'hA5A5_0000;
    end
  endtask

  task automatic apply_reset;
    rst_i       = 1'b1;
    m_req_i     = '0;
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b0;
    prio_en_i   = 1'b0;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    slv_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_i       = 1'b1;
    m_req_i     = 2'b11;
    s_gnt_i     = 1'b1;
    s_r_valid_i = 1'b1;
    #4;
    checks++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL reset_sreq got=%b want=0", s_req_o); end
    checks++; if (m_gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b want=00", m_gnt_o); end
    checks++; if (m_r_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b want=00", m_r_valid_o); end
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_outst got=%0d want=0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err_o); end
    tick();
    rst_i       = 1'b0;
    m_req_i     = '0;
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    apply_reset();
    s_gnt_i = 1'b1;
    // cycle 0: write
    set_master(0, 1'b1, mk(32'h1C00_0000, 1'b0, 32'hDEAD_BEEF));
    slave_drive(1);
    #4;
    checks++; if (m_gnt_o !== 2'b01) begin errors++; $display("FAIL single_wr_gnt got=%b want=01", m_gnt_o); end
    checks++; if ({s_add_o, s_wen_o, s_wdata_o, s_be_o} !== {32'h1C00_0000, 1'b0, 32'hDEAD_BEEF, 4'hF}) begin
      errors++; $display("FAIL single_wr_payload got=%h/%b/%h/%h", s_add_o, s_wen_o, s_wdata_o, s_be_o);
    end
    if (m_gnt_o == 2'b01) accept(0);
    tick();
    // cycles 1..3: read, then idle while responses come back
    for (int c = 1; c < 4; c++) begin
      if (c == 1) set_master(0, 1'b1, mk(32'h1C00_0000, 1'b1, 32'h0));
      else        set_master(0, 1'b0, mk(32'h1C00_0000, 1'b1, 32'h0));
      slave_drive(1);
      #4;
      checks++;
      if (m_gnt_o !== ((c == 1) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL single_gnt c=%0d got=%b", c, m_gnt_o);
      end
      if (c == 1) begin
        checks++; if (s_wen_o !== 1'b1) begin errors++; $display("FAIL single_rd_wen got=%b want=1", s_wen_o); end
      end
      if (s_r_valid_i) begin
        e = exp_q.pop_front();
        checks++;
        if (m_r_valid_o !== (NB'(1) << e.mst)) begin
          errors++; $display("FAIL single_route got=%b want_master=%0d", m_r_valid_o, e.mst);
        end
        if (e.rd) begin
          checks++;
          if (m_r_rdata_o[e.mst] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_rdata got=%h want=deadbeef", m_r_rdata_o[e.mst]);
          end
        end
      end
      if (c == 1 && m_gnt_o == 2'b01) accept(0);
      tick();
    end
    checks++; if (exp_q.size() != 0 || outstanding_o !== 3'd0) begin
      errors++; $display("FAIL single_drain left=%0d outst=%0d", exp_q.size(), outstanding_o);
    end
  endtask

  task automatic test_rr;
    exp_t          e;
    logic [NB-1:0] eg;
    apply_reset();
    mem[32'h1C00_0100] = 32'h1111_0000;
    mem[32'h1C00_0104] = 32'h2222_0001;
    set_master(0, 1'b1, mk(32'h1C00_0100, 1'b1, 32'h0));
    set_master(1, 1'b1, mk(32'h1C00_0104, 1'b1, 32'h0));
    s_gnt_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) begin
        m_req_i = '0;
      end
      eg = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      slave_drive(1);
      #4;
      checks++; if (m_gnt_o !== eg) begin errors++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, m_gnt_o, eg); end
      if (s_r_valid_i) begin
        e = exp_q.pop_front();
        checks++;
        if (m_r_valid_o !== (NB'(1) << e.mst) || m_r_rdata_o[e.mst] !== e.data) begin
          errors++; $display("FAIL rr_rsp c=%0d got=%b/%h want_master=%0d data=%h", c, m_r_valid_o, m_r_rdata_o[e.mst], e.mst, e.data);
        end
      end
      if (eg == 2'b01) accept(0);
      if (eg == 2'b10) accept(1);
      tick();
    end
  endtask

  task automatic test_prio;
    exp_t          e;
    logic [NB-1:0] eg;
    apply_reset();
    set_master(0, 1'b1, mk(32'h1C00_0100, 1'b1, 32'h0));
    set_master(1, 1'b1, mk(32'h1C00_0104, 1'b1, 32'h0));
    s_gnt_i = 1'b1;
    // c0: RR grant to 0 moves pointer to 1; c1..c4 priority; c5 RR must pick 1.
    for (int c = 0; c < 8; c++) begin
      prio_en_i = (c >= 1 && c <= 4);
      if (c == 6) m_req_i = '0;
      eg = (c >= 6) ? 2'b00 : ((c == 5) ? 2'b10 : 2'b01);
      slave_drive(1);
      #4;
      checks++; if (m_gnt_o !== eg) begin errors++; $display("FAIL prio_gnt c=%0d got=%b want=%b", c, m_gnt_o, eg); end
      if (s_r_valid_i) begin
        e = exp_q.pop_front();
        checks++;
        if (m_r_valid_o !== (NB'(1) << e.mst) || m_r_rdata_o[e.mst] !== e.data) begin
          errors++; $display("FAIL prio_rsp c=%0d got=%b want_master=%0d", c, m_r_valid_o, e.mst);
        end
      end
      if (eg == 2'b01) accept(0);
      if (eg == 2'b10) accept(1);
      tick();
    end
    prio_en_i = 1'b0;
  endtask

  task automatic test_backpressure;
    exp_t e;
    apply_reset();
    mem[32'h1C00_0200] = 32'h3333_3333;
    set_master(0, 1'b1, mk(32'h1C00_0200, 1'b1, 32'h0));
    set_master(1, 1'b0, mk(32'h1C00_0204, 1'b1, 32'h0));
    s_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      slave_drive(0);
      #4;
      checks++; if (m_gnt_o !== 2'b01) begin errors++; $display("FAIL bp_fill_gnt c=%0d got=%b want=01", c, m_gnt_o); end
      if (m_gnt_o == 2'b01) accept(0);
      tick();
    end
    slave_drive(0);
    #4;
    checks++; if (s_req_o !== 1'b0 || m_gnt_o !== 2'b00) begin errors++; $display("FAIL bp_full_block sreq=%b gnt=%b want 0/00", s_req_o, m_gnt_o); end
    checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL bp_full_outst got=%0d want=4", outstanding_o); end
    tick();
    // one response: same-cycle pop must not unblock the request
    slave_drive(1);
    #4;
    e = exp_q.pop_front();
    checks++; if (m_r_valid_o !== 2'b01) begin errors++; $display("FAIL bp_pop_route got=%b want=01", m_r_valid_o); end
    checks++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL bp_pop_sreq got=%b want=0", s_req_o); end
    tick();
    slave_drive(0);
    #4;
    checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL bp_after_pop_outst got=%0d want=3", outstanding_o); end
    checks++; if (s_req_o !== 1'b1 || m_gnt_o !== 2'b01) begin errors++; $display("FAIL bp_reassert sreq=%b gnt=%b want 1/01", s_req_o, m_gnt_o); end
    if (m_gnt_o == 2'b01) accept(0);
    tick();
    m_req_i = '0;
    for (int c = 0; c < 5; c++) begin
      slave_drive(1);
      #4;
      if (s_r_valid_i) begin
        e = exp_q.pop_front();
        checks++;
        if (m_r_valid_o !== (NB'(1) << e.mst) || m_r_rdata_o[e.mst] !== e.data) begin
          errors++; $display("FAIL bp_drain c=%0d got=%b/%h want=%h", c, m_r_valid_o, m_r_rdata_o[e.mst], e.data);
        end
      end
      tick();
    end
    #4;
    checks++; if (outstanding_o !== 3'd0 || err_o !== 1'b0) begin errors++; $display("FAIL bp_end outst=%0d err=%b want 0/0", outstanding_o, err_o); end
    tick();
  endtask

  task automatic test_stray;
    s_gnt_i     = 1'b0;
    m_req_i     = '0;
    s_r_valid_i = 1'b1;
    s_r_rdata_i = 32'h0BAD_0BAD;
    #4;
    checks++; if (m_r_valid_o !== 2'b00) begin errors++; $display("FAIL stray_rvalid got=%b want=00", m_r_valid_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL stray_err_early got=%b want=0", err_o); end
    tick();
    s_r_valid_i = 1'b0;
    #4;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL stray_err_set got=%b want=1", err_o); end
    tick();
    tick();
    tick();
    #4;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL stray_err_hold got=%b want=1", err_o); end
    tick();
  endtask

  task automatic test_reset_mid;
    set_master(0, 1'b1, mk(32'h1C00_0300, 1'b1, 32'h0));
    s_gnt_i = 1'b1;
    slave_drive(0);
    tick();
    tick();
    m_req_i = '0;
    #4;
    checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL rmid_outst got=%0d want=2", outstanding_o); end
    tick();
    rst_i       = 1'b1;
    m_req_i     = 2'b11;
    s_r_valid_i = 1'b1;
    #4;
    checks++; if (s_req_o !== 1'b0 || m_gnt_o !== 2'b00 || m_r_valid_o !== 2'b00) begin
      errors++; $display("FAIL rmid_forced sreq=%b gnt=%b rvalid=%b want 0/00/00", s_req_o, m_gnt_o, m_r_valid_o);
    end
    tick();
    rst_i       = 1'b0;
    m_req_i     = '0;
    s_r_valid_i = 1'b0;
    exp_q.delete();
    slv_q.delete();
    #4;
    checks++; if (outstanding_o !== 3'd0 || err_o !== 1'b0 || m_gnt_o !== 2'b00) begin
      errors++; $display("FAIL rmid_after outst=%0d err=%b gnt=%b want 0/0/00", outstanding_o, err_o, m_gnt_o);
    end
    tick();
    s_r_valid_i = 1'b1;
    #4;
    checks++; if (m_r_valid_o !== 2'b00) begin errors++; $display("FAIL rmid_stray_rvalid got=%b want=00", m_r_valid_o); end
    tick();
    s_r_valid_i = 1'b0;
    #4;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rmid_stray_err got=%b want=1", err_o); end
    tick();
  endtask

  initial begin
    rst_i       = 1'b1;
    prio_en_i   = 1'b0;
    m_req_i     = '0;
    m_add_i     = '0;
    m_wen_i     = '1;
    m_wdata_i   = '0;
    m_be_i      = '0;
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b0;
    s_r_rdata_i = '0;
    tick();
    test_reset();
    test_single();
    test_rr();
    test_prio();
    test_backpressure();
    test_stray();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
